// File: rtl/core_launcher_if.sv
// Host/core signal bundle for core_launcher.
// master: the launcher itself. slave: the host and the CPU top level it drives.
interface core_launcher_if #(
  parameter int CW = 16
);
  logic          start;
  logic          ack;
  logic          core_done;
  logic          core_reset;
  logic          core_req;
  logic          busy;
  logic          finished;
  logic          timed_out;
  logic [CW-1:0] cycles;
  logic [7:0]    runs;

  modport master (
    input  start, ack, core_done,
    output core_reset, core_req, busy, finished, timed_out, cycles, runs
  );

  modport slave (
    output start, ack, core_done,
    input  core_reset, core_req, busy, finished, timed_out, cycles, runs
  );
endinterface

// File: rtl/core_launcher.sv
// Run sequencer in front of the CPU top level: holds the core in reset,
// pulses req, counts RUN cycles until done, then reports until the host acks.
// Optional watchdog abort is enabled by defining WATCHDOG_EN.
//
// state | meaning
// IDLE  | core held in reset, waiting for start
// CLEAR | core reset held for RST_CYC cycles
// REQ   | single-cycle req to the core
// RUN   | counting cycles, waiting for core_done
// DONE  | run finished, core frozen, waiting for ack
// TOUT  | watchdog abort, core in reset, waiting for ack (WATCHDOG_EN only)
module core_launcher #(
  parameter int CW      = 16,
  parameter int RST_CYC = 2,
  parameter int TMO     = 4095
) (
  input logic             clk,
  input logic             reset,
  core_launcher_if.master bus
);

  localparam int RCW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  if (RST_CYC < 1 || TMO < 1) begin : g_bad_params
    $error("core_launcher: RST_CYC and TMO must be >= 1");
  end
`ifdef WATCHDOG_EN
  if (TMO >= (1 << CW) - 1) begin : g_bad_tmo
    $error("core_launcher: TMO must be below the cycle counter saturation value");
  end
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_REQ   = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
`ifdef WATCHDOG_EN
    , S_TOUT = 3'd5
`endif
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [RCW-1:0] r_clr_cnt;
  logic [RCW-1:0] w_clr_cnt_next;
  logic [CW-1:0]  r_cycles;
  logic [CW-1:0]  w_cycles_next;
  logic [7:0]     r_runs;
  logic [7:0]     w_runs_next;
  logic           w_next_tout;

  logic r_core_reset;
  logic r_core_req;
  logic r_busy;
  logic r_finished;
  logic r_timed_out;

  // Next-state, clear-timer and counter update logic
  always_comb begin
    w_next         = S_IDLE;
    w_clr_cnt_next = r_clr_cnt;
    w_cycles_next  = r_cycles;
    w_runs_next    = r_runs;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next         = S_CLEAR;
          w_clr_cnt_next = RCW'(RST_CYC - 1);
          w_cycles_next  = '0;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_CLEAR: begin
        if (r_clr_cnt == '0) begin
          w_next = S_REQ;
        end else begin
          w_next         = S_CLEAR;
          w_clr_cnt_next = r_clr_cnt - RCW'(1);
        end
      end
      S_REQ: w_next = S_RUN;
      S_RUN: begin
        if (bus.core_done) begin
          w_next      = S_DONE;
          w_runs_next = r_runs + 8'd1;
        end
`ifdef WATCHDOG_EN
        else if (r_cycles == CW'(TMO)) begin
          w_next = S_TOUT;
        end
`endif
        else begin
          w_next = S_RUN;
          if (r_cycles != '1) begin
            w_cycles_next = r_cycles + CW'(1);
          end
        end
      end
      S_DONE: w_next = bus.ack ? S_IDLE : S_DONE;
`ifdef WATCHDOG_EN
      S_TOUT: w_next = bus.ack ? S_IDLE : S_TOUT;
`endif
      default: w_next = S_IDLE;
    endcase
  end

`ifdef WATCHDOG_EN
  assign w_next_tout = (w_next == S_TOUT);
`else
  assign w_next_tout = 1'b0;
`endif

  // State register with Moore outputs decoded from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_core_reset <= 1'b1;
      r_core_req   <= 1'b0;
      r_busy       <= 1'b0;
      r_finished   <= 1'b0;
      r_timed_out  <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_core_reset <= (w_next == S_IDLE) || (w_next == S_CLEAR) || w_next_tout;
      r_core_req   <= (w_next == S_REQ);
      r_busy       <= (w_next == S_CLEAR) || (w_next == S_REQ) || (w_next == S_RUN);
      r_finished   <= (w_next == S_DONE);
      r_timed_out  <= w_next_tout;
    end
  end

  // Clear timer, cycle counter and completed-run counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clr_cnt <= '0;
      r_cycles  <= '0;
      r_runs    <= '0;
    end else begin
      r_clr_cnt <= w_clr_cnt_next;
      r_cycles  <= w_cycles_next;
      r_runs    <= w_runs_next;
    end
  end

  assign bus.core_reset = r_core_reset;
  assign bus.core_req   = r_core_req;
  assign bus.busy       = r_busy;
  assign bus.finished   = r_finished;
  assign bus.timed_out  = r_timed_out;
  assign bus.cycles     = r_cycles;
  assign bus.runs       = r_runs;

endmodule
